// File: rtl/pc_unit_ras.sv
// ---------------------------------------------------------------------------
// pc_unit_ras
//
// Program-counter unit for the word-addressed core. It picks the next PC from
// the sequential, branch, jump/jal and jr sources, supports a fetch stall, and
// keeps a circular return-address stack (RAS). Every jr target is checked
// against the predicted return address, and saturating hit/miss counters
// record how often the prediction was right.
//
// Ports:
//   clk            system clock, rising edge
//   reset          asynchronous, active-high reset
//   stall          hold PC, RAS and statistics this cycle
//   branch_taken   branch condition met (Branch & Zero)
//   branch_offset  sign-extended word offset, relative to pc+1
//   jump, jal, jr  jump instruction strobes
//   jump_index     instr[25:0], replaces the low PC bits on j/jal
//   jr_target      rs register value used by jr
//   pc             current PC
//   pc_plus_1      pc+1, the jal link value
//   imem_addr      low IMEM_AW bits of pc, for instruction memory
//   ras_top        predicted return address (0 when the stack is empty)
//   ras_count      number of valid RAS entries
//   ras_overflow   sticky: a push overwrote the oldest entry
//   ras_underflow  sticky: jr issued while the stack was empty
//   ras_hit        one-cycle pulse after a jr whose target matched ras_top
//   hit_count      saturating count of predicted jr targets
//   miss_count     saturating count of mispredicted or empty-stack jr
// ---------------------------------------------------------------------------
module pc_unit_ras #(
   parameter int                XLEN      = 32,
   parameter int                JIDX_W    = 26,
   parameter int                IMEM_AW   = 8,
   parameter int                RAS_DEPTH = 4,
   parameter int                CNT_W     = 16,
   parameter logic [XLEN-1:0]   RESET_PC  = '0
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         stall,
   input  logic                         branch_taken,
   input  logic [XLEN-1:0]              branch_offset,
   input  logic                         jump,
   input  logic                         jal,
   input  logic                         jr,
   input  logic [JIDX_W-1:0]            jump_index,
   input  logic [XLEN-1:0]              jr_target,
   output logic [XLEN-1:0]              pc,
   output logic [XLEN-1:0]              pc_plus_1,
   output logic [IMEM_AW-1:0]           imem_addr,
   output logic [XLEN-1:0]              ras_top,
   output logic [$clog2(RAS_DEPTH):0]   ras_count,
   output logic                         ras_overflow,
   output logic                         ras_underflow,
   output logic                         ras_hit,
   output logic [CNT_W-1:0]             hit_count,
   output logic [CNT_W-1:0]             miss_count
);

   localparam int PW = $clog2(RAS_DEPTH);
   localparam int CW = PW + 1;

   localparam logic [XLEN-1:0]  PC_ONE    = XLEN'(1);
   localparam logic [PW-1:0]    PTR_ONE   = PW'(1);
   localparam logic [CW-1:0]    CNT_ONE   = CW'(1);
   localparam logic [CW-1:0]    DEPTH_C   = CW'(RAS_DEPTH);
   localparam logic [CNT_W-1:0] STAT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] STAT_MAX  = '1;

   // Stack storage and the write pointer. The pointer always names the slot
   // the next push will write; the top of stack is the slot just below it.
   // Because the pointer simply wraps, a push onto a full stack lands on the
   // oldest entry, which is exactly the circular overwrite we want.
   logic [XLEN-1:0] ras_mem [RAS_DEPTH];
   logic [PW-1:0]   ras_ptr;
   logic [PW-1:0]   top_idx;

   logic [XLEN-1:0] pc_next;
   logic [XLEN-1:0] jump_dest;
   logic            do_push;
   logic            do_pop;
   logic            pop_valid;
   logic            pop_hit;
   logic            pop_miss;
   logic            stack_empty;
   logic            stack_full;

   // Values presented to the rest of the datapath are derived purely from
   // registered state so that they are stable for the whole cycle.
   always_comb begin
      pc_plus_1   = pc + PC_ONE;
      imem_addr   = pc[IMEM_AW-1:0];
      top_idx     = ras_ptr - PTR_ONE;
      stack_empty = (ras_count == '0);
      stack_full  = (ras_count == DEPTH_C);
      ras_top     = stack_empty ? '0 : ras_mem[top_idx];
   end

   // Next-PC selection with a strict priority order: jr first, then j/jal,
   // then a taken branch, and finally the sequential path. A branch offset
   // is relative to pc+1, matching the delay-free word-addressed encoding.
   // jr also outranks jal for the stack, so a push is only requested when
   // jr is low.
   always_comb begin
      jump_dest = {pc[XLEN-1:JIDX_W], jump_index};
      pc_next   = pc_plus_1;
      if (jr) begin
         pc_next = jr_target;
      end else if (jump || jal) begin
         pc_next = jump_dest;
      end else if (branch_taken) begin
         pc_next = pc_plus_1 + branch_offset;
      end
      do_pop    = jr;
      do_push   = jal && !jr;
      pop_valid = do_pop && !stack_empty;
      pop_hit   = pop_valid && (jr_target == ras_top);
      pop_miss  = do_pop && !pop_hit;
   end

   // Program counter register. A stall freezes it; otherwise it follows the
   // priority-selected next value.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc <= RESET_PC;
      end else if (!stall) begin
         pc <= pc_next;
      end
   end

   // Return-address stack storage, pointer and occupancy. A push on a full
   // stack still advances the pointer (overwriting the oldest entry) but the
   // occupancy stays pinned at the depth. A pop on an empty stack leaves the
   // pointer where it is so later pushes stay aligned.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < RAS_DEPTH; i++) begin
            ras_mem[i] <= '0;
         end
         ras_ptr   <= '0;
         ras_count <= '0;
      end else if (!stall) begin
         if (do_push) begin
            ras_mem[ras_ptr] <= pc_plus_1;
            ras_ptr          <= ras_ptr + PTR_ONE;
            if (!stack_full) begin
               ras_count <= ras_count + CNT_ONE;
            end
         end else if (pop_valid) begin
            ras_ptr   <= ras_ptr - PTR_ONE;
            ras_count <= ras_count - CNT_ONE;
         end
      end
   end

   // Sticky error flags. They record that something unusual happened at
   // least once and only a reset clears them.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ras_overflow  <= 1'b0;
         ras_underflow <= 1'b0;
      end else if (!stall) begin
         if (do_push && stack_full) begin
            ras_overflow <= 1'b1;
         end
         if (do_pop && stack_empty) begin
            ras_underflow <= 1'b1;
         end
      end
   end

   // Hit pulse and statistics. The pulse is registered so it appears in the
   // cycle after the jr and is forced low during a stall. Both counters stop
   // at all-ones rather than wrapping, so a long run never reads as small.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ras_hit    <= 1'b0;
         hit_count  <= '0;
         miss_count <= '0;
      end else if (stall) begin
         ras_hit <= 1'b0;
      end else begin
         ras_hit <= pop_hit;
         if (pop_hit && (hit_count != STAT_MAX)) begin
            hit_count <= hit_count + STAT_ONE;
         end
         if (pop_miss && (miss_count != STAT_MAX)) begin
            miss_count <= miss_count + STAT_ONE;
         end
      end
   end

endmodule

// File: tb/tb_pc_unit_ras.sv
// ---------------------------------------------------------------------------
// tb_pc_unit_ras
//
// Directed bench for pc_unit_ras. The statistics counters are built 2 bits
// wide so saturation is reachable in a handful of jr instructions; all other
// parameters keep their defaults. Expected values are worked out by hand and
// written inline at each step.
// ---------------------------------------------------------------------------
module tb_pc_unit_ras;

   localparam int XLEN   = 32;
   localparam int JIDX_W = 26;
   localparam int CNT_W  = 2;

   logic              clk;
   logic              reset;
   logic              stall;
   logic              branch_taken;
   logic [XLEN-1:0]   branch_offset;
   logic              jump;
   logic              jal;
   logic              jr;
   logic [JIDX_W-1:0] jump_index;
   logic [XLEN-1:0]   jr_target;
   logic [XLEN-1:0]   pc;
   logic [XLEN-1:0]   pc_plus_1;
   logic [7:0]        imem_addr;
   logic [XLEN-1:0]   ras_top;
   logic [2:0]        ras_count;
   logic              ras_overflow;
   logic              ras_underflow;
   logic              ras_hit;
   logic [CNT_W-1:0]  hit_count;
   logic [CNT_W-1:0]  miss_count;

   int tests;
   int fails;

   pc_unit_ras #(
      .XLEN      (XLEN),
      .JIDX_W    (JIDX_W),
      .IMEM_AW   (8),
      .RAS_DEPTH (4),
      .CNT_W     (CNT_W),
      .RESET_PC  ('0)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .stall         (stall),
      .branch_taken  (branch_taken),
      .branch_offset (branch_offset),
      .jump          (jump),
      .jal           (jal),
      .jr            (jr),
      .jump_index    (jump_index),
      .jr_target     (jr_target),
      .pc            (pc),
      .pc_plus_1     (pc_plus_1),
      .imem_addr     (imem_addr),
      .ras_top       (ras_top),
      .ras_count     (ras_count),
      .ras_overflow  (ras_overflow),
      .ras_underflow (ras_underflow),
      .ras_hit       (ras_hit),
      .hit_count     (hit_count),
      .miss_count    (miss_count)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one cycle of control inputs, let the rising edge consume them,
   // and return 1 time unit after the edge so outputs can be sampled.
   task automatic applyStimulus(input logic stl, input logic br, input logic jmp,
                                input logic jl, input logic j_r,
                                input logic [JIDX_W-1:0] idx,
                                input logic [XLEN-1:0] off,
                                input logic [XLEN-1:0] tgt);
      stall         = stl;
      branch_taken  = br;
      jump          = jmp;
      jal           = jl;
      jr            = j_r;
      jump_index    = idx;
      branch_offset = off;
      jr_target     = tgt;
      @(posedge clk);
      #1;
   endtask

   // Compare one observed value with its hand-computed expectation.
   task automatic checkOutput(input string tag, input logic [63:0] obs,
                              input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   initial begin
      tests = 0;
      fails = 0;
      reset = 1'b1;
      applyStimulusIdleInit();

      // Reset state, sampled between edges while reset is held.
      #12;
      checkOutput("reset_pc", pc, 64'h0);
      checkOutput("reset_count", ras_count, 64'h0);
      checkOutput("reset_top", ras_top, 64'h0);
      checkOutput("reset_ovf", ras_overflow, 64'h0);
      checkOutput("reset_unf", ras_underflow, 64'h0);
      checkOutput("reset_hit", ras_hit, 64'h0);
      checkOutput("reset_hitcnt", hit_count, 64'h0);
      checkOutput("reset_misscnt", miss_count, 64'h0);
      checkOutput("reset_pcp1", pc_plus_1, 64'h1);
      reset = 1'b0;

      // Three free-running cycles.
      for (int i = 1; i <= 3; i++) begin
         applyStimulus(0, 0, 0, 0, 0, '0, '0, '0);
         checkOutput("seq_pc", pc, 64'(i));
         checkOutput("seq_imem", imem_addr, 64'(i));
      end
      checkOutput("seq_count", ras_count, 64'h0);

      // Backwards branch from 0x10: 0x10 + 1 - 2 = 0x0F.
      applyStimulus(0, 0, 1, 0, 0, 26'h10, '0, '0);
      checkOutput("jump_pc", pc, 64'h10);
      applyStimulus(0, 1, 0, 0, 0, '0, 32'hFFFF_FFFE, '0);
      checkOutput("branch_back_pc", pc, 64'h0F);

      // Jump beats a branch asserted on the same edge.
      applyStimulus(0, 0, 1, 0, 0, 26'h10, '0, '0);
      applyStimulus(0, 1, 1, 0, 0, 26'h40, 32'hFFFF_FFFE, '0);
      checkOutput("jump_beats_branch", pc, 64'h40);

      // jal at 0x20 to 0x80, then return with a correctly predicted jr.
      applyStimulus(0, 0, 1, 0, 0, 26'h20, '0, '0);
      applyStimulus(0, 0, 0, 1, 0, 26'h80, '0, '0);
      checkOutput("jal_pc", pc, 64'h80);
      checkOutput("jal_top", ras_top, 64'h21);
      checkOutput("jal_count", ras_count, 64'h1);
      applyStimulus(0, 0, 0, 0, 1, '0, '0, 32'h21);
      checkOutput("jr_pc", pc, 64'h21);
      checkOutput("jr_hit", ras_hit, 64'h1);
      checkOutput("jr_hitcnt", hit_count, 64'h1);
      checkOutput("jr_count", ras_count, 64'h0);
      checkOutput("jr_top_empty", ras_top, 64'h0);
      applyStimulus(0, 0, 0, 0, 0, '0, '0, '0);
      checkOutput("hit_pulse_end", ras_hit, 64'h0);
      checkOutput("after_ret_pc", pc, 64'h22);

      // Five nested jal from pc 0..4 push link values 1..5 into a 4-deep RAS.
      applyStimulus(0, 0, 1, 0, 0, 26'h0, '0, '0);
      for (int i = 0; i < 5; i++) begin
         applyStimulus(0, 0, 0, 1, 0, 26'(i + 1), '0, '0);
         if (i == 3) begin
            checkOutput("full_no_ovf", ras_overflow, 64'h0);
         end
      end
      checkOutput("ovf_count", ras_count, 64'h4);
      checkOutput("ovf_flag", ras_overflow, 64'h1);
      checkOutput("ovf_pc", pc, 64'h5);

      // Pops return 5,4,3,2 (entry 1 was overwritten). All four are hits,
      // so the 2-bit hit counter goes 2,3,3,3.
      for (int i = 0; i < 4; i++) begin
         checkOutput("pop_top", ras_top, 64'(5 - i));
         applyStimulus(0, 0, 0, 0, 1, '0, '0, 32'(5 - i));
         checkOutput("pop_pc", pc, 64'(5 - i));
         checkOutput("pop_hit", ras_hit, 64'h1);
      end
      checkOutput("pop_count", ras_count, 64'h0);
      checkOutput("hit_saturated", hit_count, 64'h3);

      // Fifth jr on an empty stack.
      applyStimulus(0, 0, 0, 0, 1, '0, '0, 32'h30);
      checkOutput("unf_pc", pc, 64'h30);
      checkOutput("unf_flag", ras_underflow, 64'h1);
      checkOutput("unf_misscnt", miss_count, 64'h1);
      checkOutput("unf_hit", ras_hit, 64'h0);
      checkOutput("unf_count", ras_count, 64'h0);

      // jal held off by a three-cycle stall, then taking effect once.
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1, 0, 0, 1, 0, 26'h99, '0, '0);
         checkOutput("stall_pc", pc, 64'h30);
         checkOutput("stall_count", ras_count, 64'h0);
      end
      checkOutput("stall_misscnt", miss_count, 64'h1);
      checkOutput("stall_hitcnt", hit_count, 64'h3);
      applyStimulus(0, 0, 0, 1, 0, 26'h99, '0, '0);
      checkOutput("unstall_pc", pc, 64'h99);
      checkOutput("unstall_top", ras_top, 64'h31);
      applyStimulus(0, 0, 0, 0, 0, '0, '0, '0);
      checkOutput("unstall_once_pc", pc, 64'h9A);
      checkOutput("unstall_once_count", ras_count, 64'h1);

      // Mispredicted jr, then empty-stack jr: misses 2,3,3,3,3.
      applyStimulus(0, 0, 0, 0, 1, '0, '0, 32'h50);
      checkOutput("mispred_pc", pc, 64'h50);
      checkOutput("mispred_hit", ras_hit, 64'h0);
      checkOutput("mispred_misscnt", miss_count, 64'h2);
      checkOutput("mispred_count", ras_count, 64'h0);
      applyStimulus(0, 0, 0, 0, 1, '0, '0, 32'h50);
      checkOutput("miss3", miss_count, 64'h3);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(0, 0, 0, 0, 1, '0, '0, 32'h50);
      end
      checkOutput("miss_saturated", miss_count, 64'h3);

      // jr and jal together: jr wins, pops, and nothing is pushed.
      applyStimulus(0, 0, 0, 1, 0, 26'h60, '0, '0);
      checkOutput("pre_both_top", ras_top, 64'h51);
      applyStimulus(0, 0, 0, 1, 1, 26'h70, '0, 32'h51);
      checkOutput("both_pc", pc, 64'h51);
      checkOutput("both_count", ras_count, 64'h0);
      checkOutput("both_hit", ras_hit, 64'h1);

      // Asynchronous reset in the middle of a stall, checked before any edge.
      applyStimulus(1, 0, 0, 0, 0, '0, '0, '0);
      checkOutput("prereset_pc", pc, 64'h51);
      #1;
      reset = 1'b1;
      #1;
      checkOutput("async_pc", pc, 64'h0);
      checkOutput("async_unf", ras_underflow, 64'h0);
      checkOutput("async_ovf", ras_overflow, 64'h0);
      checkOutput("async_hitcnt", hit_count, 64'h0);
      checkOutput("async_misscnt", miss_count, 64'h0);
      checkOutput("async_imem", imem_addr, 64'h0);
      reset = 1'b0;
      applyStimulus(0, 0, 0, 0, 0, '0, '0, '0);
      checkOutput("post_reset_pc", pc, 64'h1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   // Quiet values for every control input before the first edge.
   task automatic applyStimulusIdleInit();
      stall         = 1'b0;
      branch_taken  = 1'b0;
      jump          = 1'b0;
      jal           = 1'b0;
      jr            = 1'b0;
      jump_index    = '0;
      branch_offset = '0;
      jr_target     = '0;
   endtask

endmodule
